hazard_unit: RTL and testbench
==============================

# hazard_unit

Combinational hazard-detection and operand-forwarding block for the 5-stage pipeline: IF, ID, EX, MEM, WB. It compares the EX-stage source registers against the destinations held in EX/MEM and MEM/WB. From that comparison it produces forwarding selects and values, a load-use stall, and per-register flushes for a taken branch resolved in MEM. An optional synchronous hazard-statistics counter block uses the clock and reset.

## Interface
Parameters: none.
- `clk`  in  1  pipeline clock; used only by the statistics counters.
- `rst`  in  1  synchronous, active-high reset; used only by the statistics counters.
- `Ra`, `Rb`  in  4  EX-stage source registers (operand 1, operand 2).
- `Rd_EXMEM`, `Rd_MEMWB`  in  4  destination registers of the instructions in MEM and WB.
- `opTypeMem`, `opTypeWB`  in  2  instruction class in MEM and WB.
- `opCodeMem`, `opCodeWB`  in  4  opcode in MEM and WB.
- `aluResult`  in  32  ALU result held in EX/MEM.
- `Result`  in  32  writeback value in MEM/WB.
- `branchTakenFlag`  in  1  branch in MEM resolved taken.
- `regWriteMem`, `regWriteWB`  in  1  write-enables from the pipeline; not used by any decision; opcode decode is authoritative.
- `Fa`, `Fb`, `Fc`  out  1  forward selects for operand 1, operand 2, and store data.
- `Forward1`, `Forward2`, `Forward3`  out  32  forwarded values.
- `stall`  out  1  load-use stall.
- `flush1`..`flush5`  out  1  flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Operation
- `writes(t,c)` is true when any of these holds:
  - t=00 (register ALU);
  - t=01 (immediate ALU);
  - t=10 and c=0000 (ldr).
- `writes(t,c)` is false for:
  - t=10 with c≠0000 (str and other memory ops);
  - t=11 (branch/control).
- `memW` = writes(opTypeMem, opCodeMem); `wbW` = writes(opTypeWB, opCodeWB).
- `isLoadMem` = opTypeMem==10 and opCodeMem==0000.
- `isStoreMem` = opTypeMem==10 and opCodeMem==0001.
- Operand 1, MEM wins over WB:
  - if memW and Ra==Rd_EXMEM and not isLoadMem: Fa=1, Forward1=aluResult;
  - else if wbW and Ra==Rd_MEMWB: Fa=1, Forward1=Result;
  - else Fa=0, Forward1=0.
- Operand 2 follows the same rule using Rb, Fb and Forward2.
- Store data: Fc=1 and Forward3=Result when isStoreMem, wbW and Rd_EXMEM==Rd_MEMWB; otherwise Fc=0 and Forward3=0.
- Stall:
  - stall=1 when isLoadMem and (Ra==Rd_EXMEM or Rb==Rd_EXMEM), and branchTakenFlag=0;
  - branch flush has priority over stall;
  - a stall never asserts any flush.
- Branch flush:
  - branchTakenFlag=1 sets flush2=flush3=flush4=1;
  - flush1 and flush5 stay 0 in all cases.
- Register 0 receives no special treatment; all 16 registers compare equal by value.

## Timing
- Every hazard output is purely combinational from the current inputs, with zero-cycle latency.
- Hazard outputs must be valid without clk toggling and without rst ever being applied; they have no reset value.
- An X on `regWriteMem` or `regWriteWB` must never propagate to any output.
- If the statistics counters are compiled in:
  - they update on the rising edge of clk;
  - rst=1 at an edge forces them to 0 and takes priority over an increment in the same cycle;
  - they wrap modulo 2^32.

## Configuration
- `HAZARD_STATS_EN` defined adds outputs `stallCount` (out, 32) and `flushCount` (out, 32):
  - `stallCount` increments on each clk edge where stall=1;
  - `flushCount` increments on each clk edge where branchTakenFlag=1.
- `HAZARD_STATS_EN` undefined: those ports and registers do not exist; clk and rst remain as unused ports; combinational behaviour is identical.

## Test plan
- No dependence: Ra=1, Rb=2, Rd_EXMEM=10, Rd_MEMWB=15, Mem=00/0010, WB=11/0010 -> stall, flush1-5, Fa and Fb all 0.
- EX/MEM forward: Rd_EXMEM=1, Mem=00/0010, aluResult=10 -> Fa=1, Forward1=10, Fb=0, stall=0.
- MEM/WB forward: Rd_EXMEM=10, Rd_MEMWB=2, WB=00/0010, Result=2 -> Fb=1, Forward2=2, Fa=0.
- Load-use: Rd_EXMEM=2, Mem=10/0000 -> stall=1, all flushes 0. Repeat with branchTakenFlag=1 -> stall=0, flush2-4=1.
- Branch: Mem=11/1011, Rd_EXMEM=2, Rb=2:
  - branchTakenFlag=0 -> all flushes 0, stall=0, Fb=0;
  - branchTakenFlag=1 -> flush2=flush3=flush4=1, flush1=flush5=0.
- Write decode: Ra=9, Rb=7, Rd_EXMEM=7, Rd_MEMWB=9:
  - Mem=11/1011, WB=10/0000 -> Fa=1 (from WB), Fb=0;
  - Mem=01/1011, WB=10/0001 -> Fa=0, Fb=1 (from MEM, value aluResult).
  - With HAZARD_STATS_EN, the counters read 0 after rst and count exactly the stall and flush cycles.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit signal bundle: EX/MEM/WB register and opcode state in,
// forwarding selects/values, stall and flushes out.
interface hazard_unit_if;
    logic [3:0]  Ra;
    logic [3:0]  Rb;
    logic [3:0]  Rd_EXMEM;
    logic [3:0]  Rd_MEMWB;
    logic [1:0]  opTypeMem;
    logic [1:0]  opTypeWB;
    logic [3:0]  opCodeMem;
    logic [3:0]  opCodeWB;
    logic [31:0] aluResult;
    logic [31:0] Result;
    logic        branchTakenFlag;
    logic        regWriteMem;
    logic        regWriteWB;

    logic        Fa;
    logic        Fb;
    logic        Fc;
    logic [31:0] Forward1;
    logic [31:0] Forward2;
    logic [31:0] Forward3;
    logic        stall;
    logic        flush1;
    logic        flush2;
    logic        flush3;
    logic        flush4;
    logic        flush5;

    // No handshake: every output is a pure function of the inputs presented in the same cycle.
    modport master (
        output Ra, Rb, Rd_EXMEM, Rd_MEMWB, opTypeMem, opTypeWB, opCodeMem, opCodeWB,
               aluResult, Result, branchTakenFlag, regWriteMem, regWriteWB,
        input  Fa, Fb, Fc, Forward1, Forward2, Forward3, stall,
               flush1, flush2, flush3, flush4, flush5
    );

    modport slave (
        input  Ra, Rb, Rd_EXMEM, Rd_MEMWB, opTypeMem, opTypeWB, opCodeMem, opCodeWB,
               aluResult, Result, branchTakenFlag, regWriteMem, regWriteWB,
        output Fa, Fb, Fc, Forward1, Forward2, Forward3, stall,
               flush1, flush2, flush3, flush4, flush5
    );
endinterface

// File: rtl/hazard_unit.sv
// Combinational forwarding / load-use stall / branch-flush unit for the 5-stage pipeline.
// Define HAZARD_STATS_EN to add the stallCount/flushCount statistics counters.
module hazard_unit (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]   stallCount,
    output logic [31:0]   flushCount
`endif
);

    function automatic logic writes(input logic [1:0] t, input logic [3:0] c);
        return (t == 2'b00) || (t == 2'b01) || ((t == 2'b10) && (c == 4'b0000));
    endfunction

    logic memW;
    logic wbW;
    logic isLoadMem;
    logic isStoreMem;

    // Opcode decode is authoritative; the pipeline write-enables are deliberately ignored.
    assign memW       = writes(hz.opTypeMem, hz.opCodeMem);
    assign wbW        = writes(hz.opTypeWB, hz.opCodeWB);
    assign isLoadMem  = (hz.opTypeMem == 2'b10) && (hz.opCodeMem == 4'b0000);
    assign isStoreMem = (hz.opTypeMem == 2'b10) && (hz.opCodeMem == 4'b0001);

    always_comb begin
        hz.Fa       = 1'b0;
        hz.Fb       = 1'b0;
        hz.Fc       = 1'b0;
        hz.Forward1 = '0;
        hz.Forward2 = '0;
        hz.Forward3 = '0;
        hz.stall    = 1'b0;
        hz.flush1   = 1'b0;
        hz.flush2   = 1'b0;
        hz.flush3   = 1'b0;
        hz.flush4   = 1'b0;
        hz.flush5   = 1'b0;

        // A load in MEM has no data yet, so it never forwards; it stalls instead.
        if (memW && (hz.Ra == hz.Rd_EXMEM) && !isLoadMem) begin
            hz.Fa       = 1'b1;
            hz.Forward1 = hz.aluResult;
        end else if (wbW && (hz.Ra == hz.Rd_MEMWB)) begin
            hz.Fa       = 1'b1;
            hz.Forward1 = hz.Result;
        end

        if (memW && (hz.Rb == hz.Rd_EXMEM) && !isLoadMem) begin
            hz.Fb       = 1'b1;
            hz.Forward2 = hz.aluResult;
        end else if (wbW && (hz.Rb == hz.Rd_MEMWB)) begin
            hz.Fb       = 1'b1;
            hz.Forward2 = hz.Result;
        end

        if (isStoreMem && wbW && (hz.Rd_EXMEM == hz.Rd_MEMWB)) begin
            hz.Fc       = 1'b1;
            hz.Forward3 = hz.Result;
        end

        if (hz.branchTakenFlag) begin
            hz.flush2 = 1'b1;
            hz.flush3 = 1'b1;
            hz.flush4 = 1'b1;
        end else if (isLoadMem && ((hz.Ra == hz.Rd_EXMEM) || (hz.Rb == hz.Rd_EXMEM))) begin
            hz.stall = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (hz.stall)           stallCount <= stallCount + 32'd1;
            if (hz.branchTakenFlag) flushCount <= flushCount + 32'd1;
        end
    end
`endif

    logic unusedInputs;
    assign unusedInputs = &{1'b0, hz.regWriteMem, hz.regWriteWB
`ifndef HAZARD_STATS_EN
                            , clk, rst
`endif
                           };

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed plan vectors plus random vectors checked
// against a priority-list reference model.
module tb_hazard_unit;

    typedef struct packed {
        logic        fa;
        logic        fb;
        logic        fc;
        logic        stall;
        logic [4:0]  flush;
        logic [31:0] f1;
        logic [31:0] f2;
        logic [31:0] f3;
    } exp_t;

    localparam int W = $bits(exp_t);

    logic clk;
    logic rst;
    hazard_unit_if hzIf ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stallCount;
    logic [31:0] flushCount;
    logic [31:0] modelStalls;
    logic [31:0] modelFlushes;

    hazard_unit dut (
        .clk        (clk),
        .rst        (rst),
        .hz         (hzIf.slave),
        .stallCount (stallCount),
        .flushCount (flushCount)
    );
`else
    hazard_unit dut (
        .clk (clk),
        .rst (rst),
        .hz  (hzIf.slave)
    );
`endif

    logic [W-1:0] exp_q[$];
    int checks;
    int failures;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic modelWrites(input logic [1:0] t, input logic [3:0] c);
        case (t)
            2'b00, 2'b01: return 1'b1;
            2'b10:        return c == 4'd0;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic [3:0]  rd[2];
        logic [31:0] val[2];
        logic        ok[2];
        logic [3:0]  src[2];
        logic        hit[2];
        logic [31:0] fv[2];
        logic        memLoad;
        logic        memStore;
        e = '0;
        memLoad  = (hzIf.opTypeMem == 2'd2) && (hzIf.opCodeMem == 4'd0);
        memStore = (hzIf.opTypeMem == 2'd2) && (hzIf.opCodeMem == 4'd1);
        // Producers in priority order: youngest (MEM) first.
        rd[0] = hzIf.Rd_EXMEM; val[0] = hzIf.aluResult;
        ok[0] = modelWrites(hzIf.opTypeMem, hzIf.opCodeMem) && !memLoad;
        rd[1] = hzIf.Rd_MEMWB; val[1] = hzIf.Result;
        ok[1] = modelWrites(hzIf.opTypeWB, hzIf.opCodeWB);
        src[0] = hzIf.Ra;
        src[1] = hzIf.Rb;
        for (int s = 0; s < 2; s++) begin
            hit[s] = 1'b0;
            fv[s]  = 32'd0;
            for (int p = 0; p < 2; p++) begin
                if (!hit[s] && ok[p] && rd[p] == src[s]) begin
                    hit[s] = 1'b1;
                    fv[s]  = val[p];
                end
            end
        end
        e.fa = hit[0]; e.f1 = fv[0];
        e.fb = hit[1]; e.f2 = fv[1];
        if (memStore && ok[1] && hzIf.Rd_EXMEM == hzIf.Rd_MEMWB) begin
            e.fc = 1'b1;
            e.f3 = hzIf.Result;
        end
        if (hzIf.branchTakenFlag)
            e.flush = 5'b01110;  // {flush5..flush1}
        else
            e.stall = memLoad && (hzIf.Ra == hzIf.Rd_EXMEM || hzIf.Rb == hzIf.Rd_EXMEM);
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rdm, input logic [3:0] rdw,
                         input logic [1:0] tm, input logic [3:0] cm,
                         input logic [1:0] tw, input logic [3:0] cw,
                         input logic [31:0] alu, input logic [31:0] res,
                         input logic bt);
        @(posedge clk);
        #1;
        hzIf.Ra = ra;          hzIf.Rb = rb;
        hzIf.Rd_EXMEM = rdm;   hzIf.Rd_MEMWB = rdw;
        hzIf.opTypeMem = tm;   hzIf.opCodeMem = cm;
        hzIf.opTypeWB = tw;    hzIf.opCodeWB = cw;
        hzIf.aluResult = alu;  hzIf.Result = res;
        hzIf.branchTakenFlag = bt;
        hzIf.regWriteMem = 1'($urandom_range(0, 1));
        hzIf.regWriteWB  = 1'($urandom_range(0, 1));
        exp_q.push_back(model());
    endtask

    function automatic logic [3:0] randOp();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 1));
    endfunction

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("Fa", {31'd0, hzIf.Fa}, {31'd0, e.fa});
            check("Fb", {31'd0, hzIf.Fb}, {31'd0, e.fb});
            check("Fc", {31'd0, hzIf.Fc}, {31'd0, e.fc});
            check("stall", {31'd0, hzIf.stall}, {31'd0, e.stall});
            check("flush", {27'd0, hzIf.flush5, hzIf.flush4, hzIf.flush3, hzIf.flush2, hzIf.flush1},
                  {27'd0, e.flush});
            check("Forward1", hzIf.Forward1, e.f1);
            check("Forward2", hzIf.Forward2, e.f2);
            check("Forward3", hzIf.Forward3, e.f3);
        end
    end

`ifdef HAZARD_STATS_EN
    always @(posedge clk) begin
        exp_t e;
        e = model();
        if (rst) begin
            modelStalls  = 32'd0;
            modelFlushes = 32'd0;
        end else begin
            if (e.stall)              modelStalls  = modelStalls + 32'd1;
            if (hzIf.branchTakenFlag) modelFlushes = modelFlushes + 32'd1;
        end
    end
`endif

    // ---------------- stimulus ----------------
    initial begin
        int waitCycles;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        // Hazard outputs need no reset; first vector is checked while rst is still high.
        drive(1, 2, 10, 15, 2'b00, 4'b0010, 2'b11, 4'b0010, 32'd77, 32'd88, 1'b0);
        drive(2, 2, 2, 15, 2'b10, 4'b0000, 2'b11, 4'b0010, 32'd5, 32'd6, 1'b0);
        @(negedge clk);
`ifdef HAZARD_STATS_EN
        check("stallCount_rst", stallCount, 32'd0);
        check("flushCount_rst", flushCount, 32'd0);
`endif
        rst = 1'b0;

        // Plan vectors
        drive(1, 2, 1, 15, 2'b00, 4'b0010, 2'b11, 4'b0010, 32'd10, 32'd99, 1'b0);
        drive(1, 2, 10, 2, 2'b00, 4'b0010, 2'b00, 4'b0010, 32'd44, 32'd2, 1'b0);
        drive(1, 2, 2, 15, 2'b10, 4'b0000, 2'b11, 4'b0010, 32'd3, 32'd4, 1'b0);
        drive(1, 2, 2, 15, 2'b10, 4'b0000, 2'b11, 4'b0010, 32'd3, 32'd4, 1'b1);
        drive(1, 2, 2, 15, 2'b11, 4'b1011, 2'b11, 4'b0010, 32'd3, 32'd4, 1'b0);
        drive(1, 2, 2, 15, 2'b11, 4'b1011, 2'b11, 4'b0010, 32'd3, 32'd4, 1'b1);
        drive(9, 7, 7, 9, 2'b11, 4'b1011, 2'b10, 4'b0000, 32'h1111, 32'h2222, 1'b0);
        drive(9, 7, 7, 9, 2'b01, 4'b1011, 2'b10, 4'b0001, 32'h3333, 32'h4444, 1'b0);
        // Store-data forward and register 0 as an ordinary register
        drive(0, 0, 0, 0, 2'b10, 4'b0001, 2'b01, 4'b0111, 32'hA, 32'hB, 1'b0);
        drive(0, 3, 5, 5, 2'b10, 4'b0001, 2'b10, 4'b0000, 32'hC, 32'hD, 1'b0);

        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), randOp(),
                  2'($urandom_range(0, 3)), randOp(),
                  $urandom, $urandom, 1'($urandom_range(0, 3) == 0));
        end

        waitCycles = 0;
        while (exp_q.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

`ifdef HAZARD_STATS_EN
        @(negedge clk);
        check("stallCount", stallCount, modelStalls);
        check("flushCount", flushCount, modelFlushes);
        rst = 1'b1;
        hzIf.branchTakenFlag = 1'b1;
        @(negedge clk);
        check("stallCount_rst2", stallCount, 32'd0);
        check("flushCount_rst2", flushCount, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
